// File: rtl/reset_ctrl_pkg.sv
// Shared types for the system reset controller.
// Holds the reset-cause codes, the sequencer states and the cause
// priority function used when several requests land in the same cycle.
package reset_ctrl_pkg;

    typedef enum logic [1:0] {
        RC_POR = 2'd0,
        RC_EXT = 2'd1,
        RC_SW  = 2'd2,
        RC_WDT = 2'd3
    } reset_cause_e;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Pad reset outranks the watchdog, which outranks software.
    function automatic reset_cause_e pick_cause(input logic ext_req,
                                                input logic wdt_expire,
                                                input logic sw_req);
        reset_cause_e cause;
        cause = RC_SW;
        if (ext_req) begin
            cause = RC_EXT;
        end else if (wdt_expire) begin
            cause = RC_WDT;
        end else if (sw_req) begin
            cause = RC_SW;
        end
        return cause;
    endfunction

endpackage

// File: rtl/reset_ctrl_debounce.sv
// Pad reset conditioner: two-flop synchronizer followed by a saturating
// low-sample filter. o_ext_req is high only after DEBOUNCE_CYCLES
// consecutive synchronized-low samples, so short pad glitches are dropped.
module reset_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ext_reset_n,
    output logic o_ext_req
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_MAX = DCW'(DEBOUNCE_CYCLES);

    logic           r_sync1;
    logic           r_sync2;
    logic [DCW-1:0] r_filt_cnt;

    // Synchronizer idles high so a pad held low through POR is seen cleanly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_ext_reset_n;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive low samples, saturate at the threshold, clear on any high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt_cnt <= '0;
        end else if (r_sync2) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt != DEB_MAX) begin
            r_filt_cnt <= r_filt_cnt + DCW'(1);
        end
    end

    assign o_ext_req = (r_filt_cnt == DEB_MAX);

endmodule

// File: rtl/reset_ctrl.sv
// System reset sequencer. Merges POR, debounced pad reset, software
// request and (optionally) a watchdog into one stretched, flop-driven,
// active-low system reset, and records the cause of the last reset.
// Optional watchdog source: define RESET_CTRL_WDT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_HOLD | sys_reset_on low, hold counter running toward release
// ST_RUN  | sys_reset_on high, watching for reset requests
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WDT_WIDTH       = 20
) (
    input  logic       clk_i,
    input  logic       async_reset_on,
    input  logic       ext_reset_ni,
    input  logic       sw_reset_req_i,
    input  logic       wdt_en_i,
    input  logic       wdt_kick_i,
    output logic       sys_reset_on,
    output logic [1:0] reset_cause_o
);

    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [HCW-1:0] r_hold_cnt;
    logic [HCW-1:0] w_hold_nxt;
    logic           r_sys_rst_n;
    logic           w_sys_rst_n_nxt;
    reset_cause_e   r_cause;
    reset_cause_e   w_cause_nxt;

    logic           w_ext_req;
    logic           w_wdt_expire;
    logic           w_any_req;

    reset_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk         (clk_i),
        .i_rst_n       (async_reset_on),
        .i_ext_reset_n (ext_reset_ni),
        .o_ext_req     (w_ext_req)
    );

`ifdef RESET_CTRL_WDT_EN
    logic [WDT_WIDTH-1:0] r_wdt_cnt;

    // Watchdog only runs while the system is out of reset and enabled.
    always_ff @(posedge clk_i or negedge async_reset_on) begin
        if (!async_reset_on) begin
            r_wdt_cnt <= '0;
        end else if ((r_state != ST_RUN) || !wdt_en_i || wdt_kick_i) begin
            r_wdt_cnt <= '0;
        end else if (!w_wdt_expire) begin
            r_wdt_cnt <= r_wdt_cnt + WDT_WIDTH'(1);
        end
    end

    assign w_wdt_expire = &r_wdt_cnt;
`else
    localparam int UNUSED_WDT_WIDTH = WDT_WIDTH;
    logic w_unused_wdt;

    assign w_unused_wdt = ^{wdt_en_i, wdt_kick_i};
    assign w_wdt_expire = 1'b0;
`endif

    assign w_any_req = w_ext_req | w_wdt_expire | sw_reset_req_i;

    // Sequencer registers; POR forces every one of them immediately.
    always_ff @(posedge clk_i or negedge async_reset_on) begin
        if (!async_reset_on) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_sys_rst_n <= 1'b0;
            r_cause     <= RC_POR;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_sys_rst_n <= w_sys_rst_n_nxt;
            r_cause     <= w_cause_nxt;
        end
    end

    // Next-state logic: stretch while the pad is held, release after the hold window.
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold_cnt;
        w_sys_rst_n_nxt = r_sys_rst_n;
        w_cause_nxt     = r_cause;
        case (r_state)
            ST_HOLD: begin
                w_sys_rst_n_nxt = 1'b0;
                if (w_ext_req) begin
                    w_hold_nxt = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt     = ST_RUN;
                    w_sys_rst_n_nxt = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + HCW'(1);
                end
            end
            ST_RUN: begin
                w_sys_rst_n_nxt = 1'b1;
                if (w_any_req) begin
                    w_state_nxt     = ST_HOLD;
                    w_sys_rst_n_nxt = 1'b0;
                    w_hold_nxt      = '0;
                    w_cause_nxt     = pick_cause(w_ext_req, w_wdt_expire, sw_reset_req_i);
                end
            end
            default: begin
                w_state_nxt     = ST_HOLD;
                w_sys_rst_n_nxt = 1'b0;
                w_hold_nxt      = '0;
            end
        endcase
    end

    assign sys_reset_on  = r_sys_rst_n;
    assign reset_cause_o = r_cause;

endmodule

// File: tb/tb_reset_ctrl.sv
// Directed bench for reset_ctrl. Build with RESET_CTRL_WDT_EN defined to
// exercise the watchdog with a 6-bit counter.
module tb_reset_ctrl;

`ifdef RESET_CTRL_WDT_EN
    localparam int WDT_W = 6;
`else
    localparam int WDT_W = 20;
`endif

    logic       clk_i = 1'b0;
    logic       async_reset_on;
    logic       ext_reset_ni;
    logic       sw_reset_req_i;
    logic       wdt_en_i;
    logic       wdt_kick_i;
    logic       sys_reset_on;
    logic [1:0] reset_cause_o;

    int checks = 0;
    int errors = 0;

    reset_ctrl #(
        .HOLD_CYCLES     (16),
        .DEBOUNCE_CYCLES (4),
        .WDT_WIDTH       (WDT_W)
    ) dut (
        .clk_i          (clk_i),
        .async_reset_on (async_reset_on),
        .ext_reset_ni   (ext_reset_ni),
        .sw_reset_req_i (sw_reset_req_i),
        .wdt_en_i       (wdt_en_i),
        .wdt_kick_i     (wdt_kick_i),
        .sys_reset_on   (sys_reset_on),
        .reset_cause_o  (reset_cause_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Posedges until sys_reset_on is high; returns 200 if it never rises.
    task automatic count_to_high(output int n);
        n = 0;
        while (sys_reset_on !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic sw_pulse();
        sw_reset_req_i = 1'b1;
        tick();
        sw_reset_req_i = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        async_reset_on = 1'b0;
        tick();
        tick();
        checks++;
        if (sys_reset_on !== 1'b0) begin
            errors++;
            $display("FAIL por_sys: got %b want 0", sys_reset_on);
        end
        checks++;
        if (reset_cause_o !== 2'd0) begin
            errors++;
            $display("FAIL por_cause: got %0d want 0", reset_cause_o);
        end
        async_reset_on = 1'b1;
        count_to_high(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL por_release_edges: got %0d want 16", n);
        end
        checks++;
        if (reset_cause_o !== 2'd0) begin
            errors++;
            $display("FAIL por_cause_after: got %0d want 0", reset_cause_o);
        end
    endtask

    task automatic test_sw();
        int n;
        tick();
        sw_pulse();
        checks++;
        if (sys_reset_on !== 1'b0) begin
            errors++;
            $display("FAIL sw_assert: got %b want 0", sys_reset_on);
        end
        checks++;
        if (reset_cause_o !== 2'd2) begin
            errors++;
            $display("FAIL sw_cause: got %0d want 2", reset_cause_o);
        end
        repeat (4) tick();
        sw_pulse();
        count_to_high(n);
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL sw_in_hold_ignored: got %0d edges want 11", n);
        end
        checks++;
        if (reset_cause_o !== 2'd2) begin
            errors++;
            $display("FAIL sw_cause_after: got %0d want 2", reset_cause_o);
        end
    endtask

    task automatic test_ext_glitch();
        logic dropped;
        dropped = 1'b0;
        ext_reset_ni = 1'b0;
        repeat (3) begin
            tick();
            if (sys_reset_on !== 1'b1) dropped = 1'b1;
        end
        ext_reset_ni = 1'b1;
        repeat (10) begin
            tick();
            if (sys_reset_on !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL ext_glitch: reset asserted=%b want 0", dropped);
        end
        checks++;
        if (reset_cause_o !== 2'd2) begin
            errors++;
            $display("FAIL ext_glitch_cause: got %0d want 2", reset_cause_o);
        end
    endtask

    task automatic test_ext_long();
        int n;
        ext_reset_ni = 1'b0;
        repeat (6) tick();
        checks++;
        if (sys_reset_on !== 1'b1) begin
            errors++;
            $display("FAIL ext_early: got %b want 1", sys_reset_on);
        end
        tick();
        checks++;
        if (sys_reset_on !== 1'b0) begin
            errors++;
            $display("FAIL ext_assert: got %b want 0", sys_reset_on);
        end
        checks++;
        if (reset_cause_o !== 2'd1) begin
            errors++;
            $display("FAIL ext_cause: got %0d want 1", reset_cause_o);
        end
        repeat (33) tick();
        ext_reset_ni = 1'b1;
        count_to_high(n);
        checks++;
        if (n != 19) begin
            errors++;
            $display("FAIL ext_stretch: got %0d edges want 19", n);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        sw_pulse();
        count_to_high(n);
        checks++;
        if (reset_cause_o !== 2'd2) begin
            errors++;
            $display("FAIL simul_pre_cause: got %0d want 2", reset_cause_o);
        end
        ext_reset_ni = 1'b0;
        repeat (6) tick();
        sw_pulse();
        checks++;
        if (sys_reset_on !== 1'b0 || reset_cause_o !== 2'd1) begin
            errors++;
            $display("FAIL simul_ext_sw: got sys=%b cause=%0d want sys=0 cause=1",
                     sys_reset_on, reset_cause_o);
        end
        ext_reset_ni = 1'b1;
        count_to_high(n);
        checks++;
        if (n != 19) begin
            errors++;
            $display("FAIL simul_release: got %0d edges want 19", n);
        end
    endtask

    task automatic test_wdt();
        int  n;
        logic dropped;
        dropped = 1'b0;
`ifdef RESET_CTRL_WDT_EN
        wdt_en_i = 1'b1;
        n = 0;
        while (sys_reset_on === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL wdt_timeout: got %0d edges want 64", n);
        end
        checks++;
        if (reset_cause_o !== 2'd3) begin
            errors++;
            $display("FAIL wdt_cause: got %0d want 3", reset_cause_o);
        end
        count_to_high(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL wdt_release: got %0d edges want 16", n);
        end
        for (int i = 1; i <= 200; i++) begin
            wdt_kick_i = (i % 50 == 0);
            tick();
            if (sys_reset_on !== 1'b1) dropped = 1'b1;
        end
        wdt_kick_i = 1'b0;
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL wdt_kicked: reset asserted=%b want 0", dropped);
        end
        repeat (63) tick();
        checks++;
        if (sys_reset_on !== 1'b1) begin
            errors++;
            $display("FAIL wdt_pre_expire: got %b want 1", sys_reset_on);
        end
        sw_pulse();
        checks++;
        if (sys_reset_on !== 1'b0 || reset_cause_o !== 2'd3) begin
            errors++;
            $display("FAIL simul_wdt_sw: got sys=%b cause=%0d want sys=0 cause=3",
                     sys_reset_on, reset_cause_o);
        end
        wdt_en_i = 1'b0;
        count_to_high(n);
`else
        wdt_en_i = 1'b1;
        repeat (200) begin
            tick();
            if (sys_reset_on !== 1'b1) dropped = 1'b1;
        end
        wdt_en_i = 1'b0;
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL wdt_off: reset asserted=%b want 0", dropped);
        end
        checks++;
        if (reset_cause_o !== 2'd1) begin
            errors++;
            $display("FAIL wdt_off_cause: got %0d want 1", reset_cause_o);
        end
`endif
    endtask

    task automatic test_por_mid_hold();
        int n;
        sw_pulse();
        repeat (7) tick();
        #2;
        async_reset_on = 1'b0;
        #1;
        checks++;
        if (sys_reset_on !== 1'b0 || reset_cause_o !== 2'd0) begin
            errors++;
            $display("FAIL por_mid_hold: got sys=%b cause=%0d want sys=0 cause=0",
                     sys_reset_on, reset_cause_o);
        end
        tick();
        async_reset_on = 1'b1;
        count_to_high(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL por_mid_release: got %0d edges want 16", n);
        end
        checks++;
        if (reset_cause_o !== 2'd0) begin
            errors++;
            $display("FAIL por_mid_cause: got %0d want 0", reset_cause_o);
        end
    endtask

    initial begin
        async_reset_on = 1'b0;
        ext_reset_ni   = 1'b1;
        sw_reset_req_i = 1'b0;
        wdt_en_i       = 1'b0;
        wdt_kick_i     = 1'b0;
        test_reset();
        test_sw();
        test_ext_glitch();
        test_ext_long();
        test_simultaneous();
        test_wdt();
        test_por_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_ctrl.md
Name: reset_ctrl

Overview:
- Reset source/sequencer for the chip's system reset network.
- Merges three request sources into one glitch-free, stretched, active-low system reset:
  - power-on reset
  - debounced external pad reset
  - software request
- An optional watchdog adds a fourth source.
- Output drives the asynchronous reset inputs of the per-domain reset synchronizers.
- Records the cause of the last reset for software readback.

Parameters:
- HOLD_CYCLES, 16, minimum cycles sys_reset_on is held low per reset event (>= 2).
- DEBOUNCE_CYCLES, 4, consecutive synchronized-low samples of ext_reset_ni required to accept a pad reset (>= 1).
- WDT_WIDTH, 20, watchdog counter width; timeout = 2^WDT_WIDTH - 1 cycles.

Ports:
- clk_i  in  1  system clock.
- async_reset_on  in  1  power-on reset, asynchronous, active-low.
- ext_reset_ni  in  1  pad reset request, asynchronous to clk_i, active-low, may glitch.
- sw_reset_req_i  in  1  single-cycle software reset request, active-high.
- wdt_en_i  in  1  watchdog enable (level).
- wdt_kick_i  in  1  watchdog service pulse.
- sys_reset_on  out  1  generated system reset, active-low, driven directly from a flop.
- reset_cause_o  out  2  cause of last reset: 0 POR, 1 EXT, 2 SW, 3 WDT.

Behaviour:
- Interface: one clock, clk_i. Reset is async_reset_on, asynchronous and active-low.
- While async_reset_on is low:
  - state = HOLD, hold counter = 0, debounce counter = 0, watchdog counter = 0.
  - ext_reset_ni synchronizer flops = 1.
  - sys_reset_on = 0, reset_cause_o = 0 (POR).
- ext path:
  - Two-flop synchronizer, then a filter counter.
  - Filter counter increments on each synchronized-low sample and saturates at DEBOUNCE_CYCLES.
  - Any synchronized-high sample clears it.
  - ext_req is asserted while the counter equals DEBOUNCE_CYCLES.
- Hold counter width is $clog2(HOLD_CYCLES+1).
- HOLD state:
  - sys_reset_on = 0.
  - Counter increments each cycle.
  - When counter == HOLD_CYCLES-1 and ext_req is low, go to RUN.
  - sys_reset_on rises at the posedge that enters RUN.
  - After POR release, sys_reset_on goes high on the HOLD_CYCLES-th posedge.
- RUN state:
  - sys_reset_on = 1.
  - Any request (ext_req, wdt_expire, sw_reset_req_i) sampled high moves to HOLD.
  - On that same posedge: sys_reset_on falls, counter clears, reset_cause_o updates.
- Simultaneous requests: priority EXT > WDT > SW for the cause code.
- Requests while in HOLD:
  - ext_req held high keeps the counter at 0 (reset stretches until release + HOLD_CYCLES). Cause is not rewritten.
  - sw_reset_req_i is ignored; no counter restart, no cause change.
- reset_cause_o holds its value across non-POR resets. Only async_reset_on writes 0.
- Mid-operation POR: async_reset_on low at any point forces the full reset values immediately, independent of clk_i.
- No combinational path from any input to sys_reset_on.

Optional Feature:
- Macro RESET_CTRL_WDT_EN.
- Defined:
  - Watchdog counter counts in RUN while wdt_en_i = 1.
  - wdt_kick_i or wdt_en_i = 0 clears it; it is also held at 0 in HOLD.
  - wdt_expire asserts when the counter reaches all-ones, causing a reset with cause 3.
- Not defined:
  - No watchdog counter.
  - wdt_en_i and wdt_kick_i are present but ignored.
  - Cause 3 is never produced.

Decomposition:
- Package reset_ctrl_pkg:
  - reset_cause_e enum {RC_POR=2'd0, RC_EXT=2'd1, RC_SW=2'd2, RC_WDT=2'd3}.
  - state_e enum {ST_HOLD, ST_RUN}.
- Sub-module reset_debounce: ext_reset_ni synchronizer plus filter counter, parameterised by DEBOUNCE_CYCLES, output ext_req.

Test Plan:
- POR: release async_reset_on -> sys_reset_on low for exactly 16 posedges, high at the 16th; reset_cause_o = 0.
- SW: one-cycle sw_reset_req_i in RUN -> sys_reset_on low at the next posedge for 16 cycles, then high; reset_cause_o = 2. A second pulse during HOLD has no effect.
- EXT glitch rejection:
  - ext_reset_ni low for 3 cycles -> no reset.
  - ext_reset_ni low for 40 cycles -> reset asserts after 2 sync + 4 filter cycles, stays low until 16 cycles after ext release.
  - reset_cause_o = 1.
- Simultaneous: sw_reset_req_i and ext_req in the same cycle -> reset_cause_o = 1. With RESET_CTRL_WDT_EN, wdt_expire and sw together -> 3.
- WDT (macro on, WDT_WIDTH=6): wdt_en_i = 1, no kick -> reset after 63 cycles, cause 3. Kicking every 50 cycles -> never resets. Macro off -> never resets.
- POR mid-HOLD: assert async_reset_on at hold count 7 -> outputs return to reset values immediately; cause = 0; full 16-cycle hold after release.
